multicycle_control_unit: RTL and testbench

//  Control unit for the multicycle RV32I core: a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WB

---
 rtl/multicycle_control_unit_pkg.sv | 75 +++++++
 rtl/multicycle_control_unit_if.sv | 49 ++++
 rtl/multicycle_control_unit_alu_decoder.sv | 55 +++++
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit_pkg                                     |
// | Purpose  : Shared types and encodings for the multicycle RV32I control     |
// |            unit: FSM state enum, ALU operation classes, opcode constants,  |
// |            datapath select encodings and the immediate-format decoder.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  // What the current state asks of the ALU; FUNCT defers to the IR fields.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format follows the opcode alone; loads and I-type ALU ops share
  // the I format, which is also the harmless choice for unsupported opcodes.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit_if                                      |
// | Purpose  : Bundle between the control unit and the multicycle datapath /   |
// |            shared memory.                                                  |
// | Ports    : IR fields op/funct3/funct7, Zero, mem_ready (to control);       |
// |            mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,          |
// |            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal,       |
// |            instret (from control).                                         |
// |            master = control unit side, slave = datapath side.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3,
  parameter int COUNT_W   = 32
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7;
  logic                 Zero;
  logic                 mem_ready;

  logic                 mem_req;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 IRWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal;
  logic [COUNT_W-1:0]   instret;

  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instret
  );

  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit_alu_decoder                             |
// | Purpose  : Combinational ALU operation decode from the state's ALU request |
// |            and the instruction's funct3 / op[5] / funct7 fields.           |
// | Ports    : aluop_i      in  aluop_e  ADD / SUB / FUNCT request             |
// |            funct3_i     in  3        IR[14:12]                             |
// |            op5_i        in  1        IR[5], distinguishes R from I-type    |
// |            funct7_i     in  1        IR[30]                                |
// |            alucontrol_o out ALUCTRL_W ALU operation code                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               aluop_i,
  input  logic [2:0]           funct3_i,
  input  logic                 op5_i,
  input  logic                 funct7_i,
  output logic [ALUCTRL_W-1:0] alucontrol_o
);

  logic [2:0] w_code;

  always_comb begin
    w_code = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // IR[30] only selects sub for register-register ops; addi has an
          // immediate bit in that position.
          3'b000:  w_code = (op5_i && funct7_i) ? ALU_SUB : ALU_ADD;
          3'b010:  w_code = ALU_SLT;
          3'b110:  w_code = ALU_OR;
          3'b111:  w_code = ALU_AND;
          default: w_code = ALU_ADD;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  generate
    if (ALUCTRL_W > 3) begin : g_wide
      assign alucontrol_o = {{(ALUCTRL_W-3){1'b0}}, w_code};
    end else begin : g_narrow
      assign alucontrol_o = w_code[ALUCTRL_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit                                         |
// | Purpose  : Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB for the        |
// |            multicycle RV32I core over a shared memory with a req/ready     |
// |            handshake; drives datapath selects/enables and counts retired   |
// |            instructions.                                                   |
// | Ports    : clk   in  1  rising-edge clock                                  |
// |            reset in  1  synchronous active-high reset                      |
// |            bus   master modport of multicycle_control_unit_if              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W    = 3,
  parameter bit HANDSHAKE_EN = 1'b1,
  parameter int COUNT_W      = 32
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] instret_q, instret_d;

  logic   w_ready;
  aluop_e w_aluop;
  logic   w_mem_req;
  logic   w_pcwrite;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;
  logic   w_adrsrc;
  logic   w_illegal;
  logic   w_retire;
  logic [1:0] w_resultsrc;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = HANDSHAKE_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_aluop     = ALUOP_ADD;
    w_mem_req   = 1'b0;
    w_pcwrite   = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_adrsrc    = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_srca      = SRCA_PC;
    w_srcb      = SRCB_RS2;

    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC as the IR is captured.
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_FOUR;
        w_resultsrc = RES_ALURESULT;
        w_mem_req   = 1'b1;
        w_pcwrite   = w_ready;
        w_irwrite   = w_ready;
        if (w_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute OldPC+imm so a branch finds its target in ALUOut.
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca  = SRCA_RS1;
        w_srcb  = SRCB_IMM;
        state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc  = 1'b1;
        w_mem_req = 1'b1;
        if (w_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = RES_READDATA;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        if (w_ready) begin
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        w_srca  = SRCA_RS1;
        w_srcb  = SRCB_RS2;
        w_aluop = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        w_srca  = SRCA_RS1;
        w_srcb  = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed here while the PC takes the target
        // already sitting in ALUOut from DECODE.
        w_srca    = SRCA_OLDPC;
        w_srcb    = SRCB_FOUR;
        w_pcwrite = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        // funct3[0] inverts the condition: beq takes on Zero, bne on !Zero.
        w_srca    = SRCA_RS1;
        w_srcb    = SRCB_RS2;
        w_aluop   = ALUOP_SUB;
        w_pcwrite = bus.Zero ^ bus.funct3[0];
        w_retire  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = w_retire ? (instret_q + COUNT_W'(1)) : instret_q;

  // Enables are forced low during reset so an aborted access never writes.
  assign bus.mem_req   = w_mem_req  & ~reset;
  assign bus.PCWrite   = w_pcwrite  & ~reset;
  assign bus.IRWrite   = w_irwrite  & ~reset;
  assign bus.MemWrite  = w_memwrite & ~reset;
  assign bus.RegWrite  = w_regwrite & ~reset;
  assign bus.AdrSrc    = w_adrsrc;
  assign bus.ResultSrc = w_resultsrc;
  assign bus.ALUSrcA   = w_srca;
  assign bus.ALUSrcB   = w_srcb;
  assign bus.ImmSrc    = imm_src_of(bus.op);
  assign bus.illegal   = w_illegal;
  assign bus.instret   = instret_q;

  multicycle_control_unit_alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .aluop_i      (w_aluop),
    .funct3_i     (bus.funct3),
    .op5_i        (bus.op[5]),
    .funct7_i     (bus.funct7),
    .alucontrol_o (bus.ALUControl)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control_unit                                      |
// | Purpose  : Self-checking bench for multicycle_control_unit. Instructions   |
// |            are issued with randomized fields and memory stalls; a          |
// |            per-instruction model predicts cycle count, enable counts, ALU  |
// |            decode, immediate format and retirement count.                  |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_multicycle_control_unit;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_JAL = 4;
  localparam int K_BR  = 5;
  localparam int K_ILL = 6;

  logic clk;
  logic reset;
  logic reset2;

  int n_checks;
  int n_fail;

  logic [31:0] m_instret;
  logic [3:0]  m_instret2;

  multicycle_control_unit_if #(.ALUCTRL_W(3), .COUNT_W(32)) bus  ();
  multicycle_control_unit_if #(.ALUCTRL_W(3), .COUNT_W(4))  bus2 ();

  multicycle_control_unit #(
    .ALUCTRL_W    (3),
    .HANDSHAKE_EN (1'b1),
    .COUNT_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multicycle_control_unit #(
    .ALUCTRL_W    (3),
    .HANDSHAKE_EN (1'b0),
    .COUNT_W      (4)
  ) dut_nohs (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input int cls, input logic [6:0] illop);
    case (cls)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_JAL:   return 7'b1101111;
      K_BR:    return 7'b1100011;
      default: return illop;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011) || (op == 7'b1101111) || (op == 7'b1100011);
  endfunction

  function automatic string cls_name(input int cls);
    case (cls)
      K_R:     return "R";
      K_I:     return "I";
      K_LW:    return "LW";
      K_SW:    return "SW";
      K_JAL:   return "JAL";
      K_BR:    return "BR";
      default: return "ILL";
    endcase
  endfunction

  // ALU operation the executing state should request.
  function automatic logic [2:0] exp_alu(input int cls, input logic [2:0] f3, input logic f7);
    if (cls == K_BR) return 3'b001;
    case (f3)
      3'b000:  return (cls == K_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input int cls);
    case (cls)
      K_SW:    return 2'b01;
      K_BR:    return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Issue one instruction starting in FETCH. sf = fetch stall cycles,
  // sm = data-access stall cycles (loads/stores only).
  task automatic run_instr(input int cls, input int sf, input int sm, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [6:0] illop);
    int len;
    int mst;
    int n_req, n_pc, n_ir, n_rw, n_mw, n_ill, n_adr, ir_at;
    int e_req, e_pc, e_rw, e_mw, e_adr, e_ill;
    bit is_mem;
    logic [2:0] alu_seen;
    logic [1:0] imm_seen;
    string nm;

    nm     = cls_name(cls);
    is_mem = (cls == K_LW) || (cls == K_SW);
    case (cls)
      K_R, K_I, K_JAL: len = sf + 4;
      K_BR:            len = sf + 3;
      K_LW:            len = sf + sm + 5;
      K_SW:            len = sf + sm + 4;
      default:         len = sf + 2;
    endcase
    mst = sf + 3;

    bus.op     = op_of(cls, illop);
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.Zero   = z;

    n_req = 0; n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0; n_ill = 0; n_adr = 0; ir_at = -1;
    alu_seen = 3'b111;
    imm_seen = 2'b00;

    for (int i = 0; i < len; i++) begin
      if (i < sf)                                   bus.mem_ready = 1'b0;
      else if (i == sf)                             bus.mem_ready = 1'b1;
      else if (is_mem && i >= mst && i < mst + sm)  bus.mem_ready = 1'b0;
      else if (is_mem && i == mst + sm)             bus.mem_ready = 1'b1;
      else                                          bus.mem_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (bus.mem_req)  n_req++;
      if (bus.PCWrite)  n_pc++;
      if (bus.RegWrite) n_rw++;
      if (bus.MemWrite) n_mw++;
      if (bus.illegal)  n_ill++;
      if (bus.AdrSrc)   n_adr++;
      if (bus.IRWrite) begin
        n_ir++;
        ir_at = i;
      end
      if (i == sf + 1) imm_seen = bus.ImmSrc;
      if (i == sf + 2) alu_seen = bus.ALUControl;
      @(posedge clk);
      #1;
    end

    if (cls != K_ILL) m_instret = m_instret + 32'd1;
    e_req = (sf + 1) + (is_mem ? sm + 1 : 0);
    e_pc  = 1 + ((cls == K_JAL) ? 1 : 0) + ((cls == K_BR && (z ^ f3[0])) ? 1 : 0);
    e_rw  = (cls == K_R || cls == K_I || cls == K_JAL || cls == K_LW) ? 1 : 0;
    e_mw  = (cls == K_SW) ? sm + 1 : 0;
    e_adr = is_mem ? sm + 1 : 0;
    e_ill = (cls == K_ILL) ? 1 : 0;

    chk({nm, ".mem_req_cycles"},  n_req, e_req);
    chk({nm, ".pcwrite_cycles"},  n_pc,  e_pc);
    chk({nm, ".irwrite_cycles"},  n_ir,  1);
    chk({nm, ".irwrite_at"},      ir_at, sf);
    chk({nm, ".regwrite_cycles"}, n_rw,  e_rw);
    chk({nm, ".memwrite_cycles"}, n_mw,  e_mw);
    chk({nm, ".adrsrc_cycles"},   n_adr, e_adr);
    chk({nm, ".illegal_pulses"},  n_ill, e_ill);
    chk({nm, ".immsrc"},          imm_seen, exp_imm(cls));
    if (cls == K_R || cls == K_I || cls == K_BR)
      chk({nm, ".alucontrol"}, alu_seen, exp_alu(cls, f3, f7));
    chk({nm, ".instret"}, bus.instret, m_instret);
  endtask

  // Confirm the FSM sits in FETCH; mem_ready is held low so it stays there.
  task automatic check_fetch(input string tag);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".fetch_sig"}, {bus.mem_req, bus.AdrSrc, bus.ResultSrc, bus.ALUSrcB}, {1'b1, 1'b0, 2'b10, 2'b10});
    chk({tag, ".instret"}, bus.instret, m_instret);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] f3;
    logic [6:0] illop;
    int cls;

    n_checks   = 0;
    n_fail     = 0;
    m_instret  = '0;
    m_instret2 = '0;
    reset      = 1'b1;
    reset2     = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7 = 1'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.op = 7'b0110011; bus2.funct3 = '0; bus2.funct7 = 1'b0; bus2.Zero = 1'b0; bus2.mem_ready = 1'b0;

    // Reset: enables stay low even with mem_ready asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset.enables", {bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 5'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_fetch("post_reset");

    // add x3,x1,x2
    run_instr(K_R, 0, 0, 3'b000, 1'b0, 1'b0, 7'h00);

    // Reset held 3 cycles while a store is stalled in MEMWRITE.
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (i == 3) chk("sw_abort.memwrite_before", bus.MemWrite, 1'b1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sw_abort.enables_in_reset", {bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 5'b0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    m_instret = '0;
    check_fetch("sw_abort");

    // Directed cases.
    run_instr(K_LW,  0, 2, 3'b010, 1'b0, 1'b0, 7'h00);
    run_instr(K_BR,  0, 0, 3'b000, 1'b0, 1'b1, 7'h00);
    run_instr(K_BR,  0, 0, 3'b001, 1'b0, 1'b1, 7'h00);
    run_instr(K_ILL, 0, 0, 3'b000, 1'b0, 1'b0, 7'h7F);
    run_instr(K_R,   0, 0, 3'b000, 1'b1, 1'b0, 7'h00);
    run_instr(K_I,   1, 0, 3'b000, 1'b1, 1'b0, 7'h00);
    run_instr(K_SW,  1, 3, 3'b010, 1'b0, 1'b0, 7'h00);
    run_instr(K_JAL, 2, 0, 3'b000, 1'b0, 1'b0, 7'h00);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 6));
      f3  = 3'($urandom_range(0, 7));
      if (cls == K_BR) f3 = {2'b00, f3[0]};
      illop = 7'h7F;
      for (int t = 0; t < 20; t++) begin
        illop = 7'($urandom_range(0, 127));
        if (!is_legal(illop)) break;
      end
      if (is_legal(illop)) illop = 7'h7F;
      run_instr(cls, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), f3,
                ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), illop);
    end
    check_fetch("random_end");

    // Handshake disabled, 4-bit counter: no stalls with mem_ready low, wrap at 16.
    reset2 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) chk("nohs.irwrite_first_cycle", bus2.IRWrite, 1'b1);
        if (i == 3) chk("nohs.regwrite_aluwb", bus2.RegWrite, 1'b1);
        @(posedge clk);
        #1;
      end
      m_instret2 = m_instret2 + 4'd1;
      chk("nohs.instret_wrap", bus2.instret, m_instret2);
    end
    bus2.op = 7'b0000011;
    bus2.funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) chk("nohs.lw_memread_req", {bus2.mem_req, bus2.AdrSrc}, 2'b11);
      if (i == 4) chk("nohs.lw_memwb_regwrite", bus2.RegWrite, 1'b1);
      @(posedge clk);
      #1;
    end
    m_instret2 = m_instret2 + 4'd1;
    chk("nohs.lw_instret", bus2.instret, m_instret2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
